// File: rtl/kmeans_pkg.sv
// Shared widths, divider length and FSM encoding for the k-means centroid update stage.
package kmeans_pkg;
  localparam int COORD_W    = 32;
  localparam int ACC_W      = 64;
  localparam int CNT_W      = 32;
  localparam int DIV_CYCLES = 64;

  typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, FIN} cu_state_t;

  // Quotients that do not fit a coordinate clamp to the largest coordinate.
  function automatic logic [COORD_W-1:0] sat_quot(input logic [ACC_W-1:0] q);
    return (|q[ACC_W-1:COORD_W]) ? {COORD_W{1'b1}} : q[COORD_W-1:0];
  endfunction
endpackage

// File: rtl/centroid_update_if.sv
// Accumulator/classifier-facing bundle of centroid_update: inputs from the system, centroid set out.
interface centroid_update_if #(
  parameter int N = 8,
  parameter int D = 2
);
  import kmeans_pkg::*;

  logic [2**N-1:0][D-1:0][COORD_W-1:0] seed;
  logic                                seed_load;
  logic [2**N-1:0][D-1:0][ACC_W-1:0]   accu;
  logic [2**N-1:0][CNT_W-1:0]          incr;
  logic                                start;
  logic [2**N-1:0][D-1:0][COORD_W-1:0] centroids;
  logic                                busy;
  logic                                done;
  logic                                changed;

  modport master (
    output seed, seed_load, accu, incr, start,
    input  centroids, busy, done, changed
  );

  modport slave (
    input  seed, seed_load, accu, incr, start,
    output centroids, busy, done, changed
  );
endinterface

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first, DIV_CYCLES iterations per start.
module serial_divider
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [ACC_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             done_o,
  output logic [ACC_W-1:0] quot_o
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [ACC_W-1:0] dvd_q, dvd_d;
  logic [CNT_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W:0]   trial, diff;

  // Dividend register doubles as the quotient: bits shift out the top, quotient bits enter the bottom.
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    trial = {rem_q, dvd_q[ACC_W-1]};
    diff  = trial - {1'b0, dvs_q};
    if (start_i) begin
      dvd_d = dividend_i;
      dvs_d = divisor_i;
      rem_d = '0;
      cnt_d = CW'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = diff[CNT_W-1:0];
        dvd_d = {dvd_q[ACC_W-2:0], 1'b1};
      end else begin
        rem_d = trial[CNT_W-1:0];
        dvd_d = {dvd_q[ACC_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  // High during the final iteration; the quotient is complete on the following cycle.
  assign done_o = (cnt_q == CW'(1));
  assign quot_o = dvd_q;
endmodule

// File: rtl/centroid_update.sv
// Serial centroid update: divides per-class sums by counts into the centroid registers and flags movement.
module centroid_update
  import kmeans_pkg::*;
#(
  parameter int n = 8,
  parameter int d = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  centroid_update_if.slave  bus
);
  localparam int NC = 2**n;
  localparam int KW = (n > 0) ? n : 1;
  localparam int JW = (d > 1) ? $clog2(d) : 1;

  cu_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic chg_q, chg_d;
  logic changed_q, changed_d;
  logic zero_q, zero_d;
  logic busy_q, done_q;
  logic [NC-1:0][d-1:0][COORD_W-1:0] cent_q;

  logic               div_start, div_done;
  logic [ACC_W-1:0]   div_quot;
  logic [COORD_W-1:0] old_val, result;
  logic               last_elem, cent_we, seed_we;

  serial_divider u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (bus.accu[k_q][j_q]),
    .divisor_i  (bus.incr[k_q]),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  // An empty cluster keeps its previous position instead of dividing by zero.
  assign old_val   = cent_q[k_q][j_q];
  assign result    = zero_q ? old_val : sat_quot(div_quot);
  assign last_elem = (k_q == KW'(NC - 1)) && (j_q == JW'(d - 1));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    j_d       = j_q;
    chg_d     = chg_q;
    changed_d = changed_q;
    zero_d    = zero_q;
    div_start = 1'b0;
    cent_we   = 1'b0;
    seed_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          seed_we = 1'b1;
        end else if (bus.start) begin
          k_d     = '0;
          j_d     = '0;
          chg_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        zero_d    = (bus.incr[k_q] == '0);
        div_start = ~zero_d;
        state_d   = zero_d ? STORE : DIV;
      end
      DIV: begin
        if (div_done) state_d = STORE;
      end
      STORE: begin
        cent_we = 1'b1;
        chg_d   = chg_q | (result != old_val);
        if (j_q == JW'(d - 1)) begin
          j_d = '0;
          k_d = k_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        state_d = last_elem ? FIN : LOAD;
      end
      FIN: begin
        changed_d = chg_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      j_q       <= '0;
      chg_q     <= 1'b0;
      changed_q <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cent_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      j_q       <= j_d;
      chg_q     <= chg_d;
      changed_q <= changed_d;
      zero_q    <= zero_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == FIN);
      if (seed_we)      cent_q            <= bus.seed;
      else if (cent_we) cent_q[k_q][j_q]  <= result;
    end
  end

  assign bus.centroids = cent_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.changed   = changed_q;
endmodule

// File: tb/tb_centroid_update.sv
// Randomised self-checking bench for centroid_update against a plain-arithmetic k-means update model.
module tb_centroid_update;
  import kmeans_pkg::*;

  localparam int N  = 3;
  localparam int D  = 2;
  localparam int NC = 2**N;
  localparam int FULL_PASS = NC * D * 66 + 1;

  typedef logic [NC-1:0][D-1:0][COORD_W-1:0] cent_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    errors = 0;
  cent_t m_cent;
  logic  m_chg;
  int    m_cyc;

  centroid_update_if #(.N(N), .D(D)) bus ();
  centroid_update #(.n(N), .d(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: each centroid becomes sum/count (truncated, clamped), empty clusters stay put.
  task automatic model_pass();
    logic [ACC_W-1:0]   q;
    logic [COORD_W-1:0] r;
    m_chg = 1'b0;
    m_cyc = 1;
    for (int k = 0; k < NC; k++) begin
      for (int j = 0; j < D; j++) begin
        if (bus.incr[k] == 0) begin
          m_cyc += 2;
        end else begin
          m_cyc += 66;
          q = bus.accu[k][j] / {32'd0, bus.incr[k]};
          r = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
          if (r != m_cent[k][j]) m_chg = 1'b1;
          m_cent[k][j] = r;
        end
      end
    end
  endtask

  task automatic run_pass(output int cyc);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.done !== 1'b1) cyc = -1;
    @(posedge clk); #1;
  endtask

  task automatic load_seed(input cent_t s);
    bus.seed = s;
    bus.seed_load = 1'b1;
    @(posedge clk); #1 bus.seed_load = 1'b0;
    m_cent = s;
  endtask

  task automatic rand_inputs(input int zero_one_in);
    for (int k = 0; k < NC; k++) begin
      if (zero_one_in > 0 && $urandom_range(zero_one_in - 1, 0) == 0) bus.incr[k] = 32'd0;
      else bus.incr[k] = ($urandom >> $urandom_range(31, 0)) | 32'd1;
      for (int j = 0; j < D; j++) bus.accu[k][j] = {$urandom, $urandom} >> $urandom_range(63, 0);
    end
  endtask

  function automatic cent_t rand_cent();
    cent_t c;
    for (int k = 0; k < NC; k++)
      for (int j = 0; j < D; j++) c[k][j] = $urandom;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b exp 0", bus.done); end
    if (bus.changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b exp 0", bus.changed); end
    if (bus.centroids !== cent_t'(0)) begin errors++; $display("FAIL reset_cent: got %h exp 0", bus.centroids); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_cent = '0;
    m_chg  = 1'b0;
  endtask

  task automatic test_basic(input string nm, input logic exp_chg);
    int cyc;
    bus.incr = {NC{32'd4}};
    bus.accu = {(NC*D){64'd40}};
    model_pass();
    run_pass(cyc);
    checks += 4;
    if (cyc != FULL_PASS) begin errors++; $display("FAIL %s_cycles: got %0d exp %0d", nm, cyc, FULL_PASS); end
    if (bus.centroids !== {(NC*D){32'd10}}) begin errors++; $display("FAIL %s_cent: got %h exp all 10", nm, bus.centroids); end
    if (bus.centroids !== m_cent) begin errors++; $display("FAIL %s_model: got %h exp %h", nm, bus.centroids, m_cent); end
    if (bus.changed !== exp_chg) begin errors++; $display("FAIL %s_changed: got %b exp %b", nm, bus.changed, exp_chg); end
  endtask

  task automatic test_empty_class();
    int    cyc;
    cent_t s;
    s = rand_cent();
    s[3][0] = 32'd7;
    s[3][1] = 32'd9;
    load_seed(s);
    rand_inputs(0);
    bus.incr = {NC{32'd1}};
    bus.incr[3] = 32'd0;
    model_pass();
    run_pass(cyc);
    checks += 4;
    if (cyc != FULL_PASS - 128 || cyc != m_cyc) begin errors++; $display("FAIL empty_cycles: got %0d exp %0d", cyc, FULL_PASS - 128); end
    if (bus.centroids[3][0] !== 32'd7 || bus.centroids[3][1] !== 32'd9)
      begin errors++; $display("FAIL empty_class3: got %0d,%0d exp 7,9", bus.centroids[3][0], bus.centroids[3][1]); end
    if (bus.centroids !== m_cent) begin errors++; $display("FAIL empty_cent: got %h exp %h", bus.centroids, m_cent); end
    if (bus.changed !== m_chg) begin errors++; $display("FAIL empty_changed: got %b exp %b", bus.changed, m_chg); end
  endtask

  task automatic test_saturate();
    int cyc;
    rand_inputs(0);
    bus.accu[0][0] = 64'h1_0000_0000_0000;
    bus.incr[0]    = 32'd1;
    model_pass();
    run_pass(cyc);
    checks += 3;
    if (cyc != m_cyc) begin errors++; $display("FAIL sat_cycles: got %0d exp %0d", cyc, m_cyc); end
    if (bus.centroids[0][0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_value: got %h exp ffffffff", bus.centroids[0][0]); end
    if (bus.centroids !== m_cent) begin errors++; $display("FAIL sat_cent: got %h exp %h", bus.centroids, m_cent); end
    bus.accu[0][0] = 64'h1_FFFF_FFFD;
    bus.accu[0][1] = 64'd7;
    bus.incr[0]    = 32'd2;
    bus.accu[1][0] = 64'h2_0000_0000;
    bus.accu[1][1] = 64'h1_FFFF_FFFE;
    bus.incr[1]    = 32'd2;
    model_pass();
    run_pass(cyc);
    checks += 3;
    if (bus.centroids[0][1] !== 32'd3) begin errors++; $display("FAIL trunc_value: got %0d exp 3", bus.centroids[0][1]); end
    if (bus.centroids[0][0] !== 32'hFFFF_FFFE || bus.centroids[1][0] !== 32'hFFFF_FFFF || bus.centroids[1][1] !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL sat_edge: got %h %h %h exp fffffffe ffffffff ffffffff",
                               bus.centroids[0][0], bus.centroids[1][0], bus.centroids[1][1]); end
    if (bus.centroids !== m_cent) begin errors++; $display("FAIL trunc_cent: got %h exp %h", bus.centroids, m_cent); end
  endtask

  task automatic test_random();
    int cyc;
    for (int p = 0; p < 3; p++) begin
      if (p == 1) load_seed(rand_cent());
      rand_inputs(4);
      model_pass();
      run_pass(cyc);
      checks += 3;
      if (cyc != m_cyc) begin errors++; $display("FAIL rand%0d_cycles: got %0d exp %0d", p, cyc, m_cyc); end
      if (bus.centroids !== m_cent) begin errors++; $display("FAIL rand%0d_cent: got %h exp %h", p, bus.centroids, m_cent); end
      if (bus.changed !== m_chg) begin errors++; $display("FAIL rand%0d_changed: got %b exp %b", p, bus.changed, m_chg); end
    end
  endtask

  task automatic test_ignore_busy();
    int   cyc;
    logic busy_mid;
    rand_inputs(4);
    model_pass();
    busy_mid = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 5000) begin
      if (cyc == 300) begin
        busy_mid      = bus.busy;
        bus.seed      = rand_cent();
        bus.start     = 1'b1;
        bus.seed_load = 1'b1;
      end
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
      cyc++;
    end
    if (bus.done !== 1'b1) cyc = -1;
    @(posedge clk); #1;
    checks += 4;
    if (busy_mid !== 1'b1) begin errors++; $display("FAIL busy_high: got %b exp 1", busy_mid); end
    if (cyc != m_cyc) begin errors++; $display("FAIL busy_cycles: got %0d exp %0d", cyc, m_cyc); end
    if (bus.centroids !== m_cent) begin errors++; $display("FAIL busy_cent: got %h exp %h", bus.centroids, m_cent); end
    if (bus.changed !== m_chg) begin errors++; $display("FAIL busy_changed: got %b exp %b", bus.changed, m_chg); end
  endtask

  task automatic test_both_idle();
    cent_t s;
    logic  quiet;
    s = rand_cent();
    bus.seed      = s;
    bus.seed_load = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    bus.start     = 1'b0;
    m_cent = s;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    checks += 3;
    if (bus.centroids !== s) begin errors++; $display("FAIL both_seed: got %h exp %h", bus.centroids, s); end
    if (quiet !== 1'b1) begin errors++; $display("FAIL both_nopass: got busy/done activity exp none"); end
    if (bus.changed !== m_chg) begin errors++; $display("FAIL both_changed: got %b exp %b", bus.changed, m_chg); end
  endtask

  task automatic test_reset_midpass();
    int   cyc;
    logic done_seen;
    rand_inputs(0);
    done_seen = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int c = 1; c < 1000; c++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", bus.busy); end
    if (bus.centroids !== cent_t'(0)) begin errors++; $display("FAIL rstmid_cent: got %h exp 0", bus.centroids); end
    if (bus.changed !== 1'b0) begin errors++; $display("FAIL rstmid_changed: got %b exp 0", bus.changed); end
    for (int i = 0; i < 3; i++) begin
      if (bus.done === 1'b1) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL rstmid_done: got pulse exp none"); end
    m_cent = '0;
    m_chg  = 1'b0;
    model_pass();
    run_pass(cyc);
    checks += 3;
    if (cyc != m_cyc) begin errors++; $display("FAIL rstpass_cycles: got %0d exp %0d", cyc, m_cyc); end
    if (bus.centroids !== m_cent) begin errors++; $display("FAIL rstpass_cent: got %h exp %h", bus.centroids, m_cent); end
    if (bus.changed !== m_chg) begin errors++; $display("FAIL rstpass_changed: got %b exp %b", bus.changed, m_chg); end
  endtask

  initial begin
    bus.seed      = '0;
    bus.seed_load = 1'b0;
    bus.accu      = '0;
    bus.incr      = '0;
    bus.start     = 1'b0;
    test_reset();
    load_seed({(NC*D){32'd5}});
    test_basic("basic", 1'b1);
    test_basic("repeat", 1'b0);
    test_empty_class();
    test_saturate();
    test_random();
    test_ignore_busy();
    test_both_idle();
    test_reset_midpass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/centroid_update.md
# centroid_update

Downstream stage of the k-means per-class accumulator. On command, it divides each class's 64-bit coordinate sums by that class's 32-bit point count to produce the next centroid set. It holds that set in registers that drive the classifier/accumulator centroid inputs, and it reports whether any centroid moved, which is the convergence signal. Division is serial, one divider time-shared over all 2**n × d elements.

## Interface
- `n`, default 8: log2 of the number of clusters.
- `d`, default 2: number of dimensions.

- `clk`  in  1: clock; all state updates on rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `seed`  in  [31:0] [2**n-1:0][d-1:0]: initial centroids.
- `seed_load`  in  1: loads `seed` into the centroid registers; honoured only in IDLE.
- `accu`  in  [63:0] [2**n-1:0][d-1:0]: per-class coordinate sums from the accumulator.
- `incr`  in  [31:0] [2**n-1:0]: per-class point counts from the accumulator.
- `start`  in  1: single-cycle request to run one update pass.
- `centroids`  out  [31:0] [2**n-1:0][d-1:0]: registered current centroids.
- `busy`  out  1: high while a pass is in progress.
- `done`  out  1: one-cycle pulse at the end of a pass.
- `changed`  out  1: registered; 1 if any centroid value differed in the last pass.

## Operation
- States:
  - IDLE: waiting.
  - LOAD: latch one dividend/divisor pair.
  - DIV: serial division in progress.
  - STORE: write one centroid element.
  - FIN: pass complete.
- Element order: class k from 0 to 2**n-1 (outer loop), dimension j from 0 to d-1 (inner loop).
- IDLE behaviour:
  - `seed_load`=1 copies `seed` into `centroids`; `changed` is unchanged.
  - `start`=1 (if `seed_load` is 0) clears k, j and the running change flag, then goes to LOAD.
  - If `seed_load` and `start` are both high, the load wins and `start` is dropped.
- LOAD: latch `accu[k][j]` as dividend and `incr[k]` as divisor.
  - Divisor 0 → STORE directly; the result equals the old centroid (empty cluster keeps its position).
  - Otherwise → DIV.
- DIV: unsigned restoring division, one quotient bit per cycle, 64 cycles, MSB first.
  - Quotient truncates toward zero.
  - If quotient bits [63:32] are nonzero, the result saturates to 32'hFFFF_FFFF.
- STORE:
  - Running change flag |= (result != `centroids[k][j]`), compared against the pre-write value.
  - Write the result into `centroids[k][j]`.
  - Advance j; on wrap advance k.
  - If the last element was just written → FIN, else → LOAD.
- FIN: `done`=1 for this cycle, `changed` takes the running flag, then → IDLE.
- `start` outside IDLE is ignored.
- `accu` and `incr` must be held stable by the system while `busy`=1; the block does not snapshot them beyond the per-element LOAD.

## Timing
- Reset values: state IDLE, all `centroids` 0, `busy` 0, `done` 0, `changed` 0, divider registers 0.
- `busy` = (state != IDLE), registered. It is high the cycle after `start` is accepted, and low again the cycle after FIN.
- Cycles per element: nonzero count 66 (LOAD 1 + DIV 64 + STORE 1); zero count 2.
- Pass length from `start` accepted to the `done` cycle: sum of per-element cycles + 1.
  - With all counts nonzero and defaults: 256×2×66 + 1 = 33793 cycles.
- `centroids[k][j]` updates at the STORE edge; each element becomes visible downstream individually as the pass proceeds.
- Reset mid-pass: immediate return to IDLE with all reset values; the partial pass is discarded.

## Structure
- `kmeans_pkg` holds:
  - widths `COORD_W`=32, `ACC_W`=64, `CNT_W`=32;
  - `DIV_CYCLES`=64;
  - the state enum `cu_state_t` {IDLE, LOAD, DIV, STORE, FIN}.
- One sub-module: `serial_divider`. It has a `start`/`done` handshake, takes a 64-bit dividend and 32-bit divisor, and returns a 64-bit quotient after 64 cycles. `centroid_update` owns saturation and the zero-divisor bypass.

## Test plan
- Seed all centroids 5, all `incr`=4, all `accu`=40, start. Required: all centroids 10, `changed`=1, `done` exactly 33793 cycles after `start` accepted.
- Same inputs, second start. Required: centroids stay 10, `changed`=0.
- `incr[3]`=0, `seed[3]`={7,9}, other classes counts 1. Required: class 3 stays {7,9}, and class 3 takes 2 cycles per element (pass shortens by 128 cycles).
- `accu[0][0]`=64'h1_0000_0000_0000, `incr[0]`=1. Required: `centroids[0][0]`=32'hFFFF_FFFF. `accu[0][1]`=7, `incr[0]`=2 → 3 (truncation).
- Assert `rst_n`=0 at cycle 1000 of a pass. Required: `busy`=0, all centroids 0, `done` never pulses. A later start runs a full pass.
- Pulse `start` and `seed_load` while `busy`. Required: no effect on the pass and no early `done`. Then both high together in IDLE: seed loaded, no pass started.
